// File: rtl/present_ctr_feeder.sv
// rtl/present_ctr_feeder.sv - CTR-mode counter/key front end for a 32-stage PRESENT-80 pipeline
//
// Issues counter blocks {nonce, ctr} and the round-0 key into a fixed-latency
// PRESENT-80 encrypt pipeline that has no valid or stall, tracks in-flight
// blocks with a valid shift register, and re-emits the pipeline output as a
// qualified keystream.
//
// Optional feature macro: PRESENT_CTR_TAG_EN (adds ks_idx counter tag output).
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   key_ld, key_in  key register load (IDLE only)
//   nonce, ctr_init, nblk, start   run parameters, sampled on an accepted start
//   hold            insert a bubble instead of issuing this cycle
//   m, k            counter block and key to the pipeline (registered)
//   c_in            pipeline ciphertext
//   ks_valid, ks_data  qualified keystream (ks_data = c_in)
//   busy, done      run status; done pulses once per run
//   ks_idx          counter value of the block on ks_data (PRESENT_CTR_TAG_EN only)

module present_ctr_feeder #(
    parameter int LAT  = 33,
    parameter int NBW  = 16,
    parameter int CTRW = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               key_ld,
    input  logic [79:0]        key_in,
    input  logic [63-CTRW:0]   nonce,
    input  logic [CTRW-1:0]    ctr_init,
    input  logic [NBW-1:0]     nblk,
    input  logic               start,
    input  logic               hold,
    output logic [63:0]        m,
    output logic [79:0]        k,
    input  logic [63:0]        c_in,
    output logic               ks_valid,
    output logic [63:0]        ks_data,
    output logic               busy,
    output logic               done
`ifdef PRESENT_CTR_TAG_EN
    ,
    output logic [CTRW-1:0]    ks_idx
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [63-CTRW:0] nonce_r;
    logic [CTRW-1:0]  ctr;
    logic [NBW-1:0]   remaining;

    // vld[0] marks "m holds a freshly issued block this cycle"; the bit then
    // walks LAT stages so vld[LAT] lines up with that block's ciphertext.
    logic [LAT:0]     vld;

    logic accept;
    logic issue;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        issue    = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept   = 1'b1;
                    state_nx = (nblk != '0) ? RUN : DRAIN;
                end
            end
            RUN: begin
                if (!hold) begin
                    issue = 1'b1;
                    if (remaining == NBW'(1)) begin
                        state_nx = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Leaving only when nothing is in flight keeps the pipeline
                // clean for a back-to-back run.
                if (vld == '0) begin
                    done     = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m         <= '0;
            k         <= '0;
            nonce_r   <= '0;
            ctr       <= '0;
            remaining <= '0;
            vld       <= '0;
        end else begin
            // Key changes only between runs, so k is stable for a whole run.
            if (state == IDLE && key_ld) begin
                k <= key_in;
            end
            if (accept) begin
                nonce_r   <= nonce;
                ctr       <= ctr_init;
                remaining <= nblk;
            end
            if (issue) begin
                m         <= {nonce_r, ctr};
                ctr       <= ctr + CTRW'(1);
                remaining <= remaining - NBW'(1);
            end
            vld <= {vld[LAT-1:0], issue};
        end
    end

`ifdef PRESENT_CTR_TAG_EN
    // Counter tag follows vld[1..LAT]; the low CTRW bits of m are the counter.
    logic [CTRW-1:0] tag_sr [LAT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) begin
                tag_sr[i] <= '0;
            end
        end else begin
            tag_sr[0] <= m[CTRW-1:0];
            for (int i = 1; i < LAT; i++) begin
                tag_sr[i] <= tag_sr[i-1];
            end
        end
    end

    assign ks_idx = tag_sr[LAT-1];
`endif

    assign ks_valid = vld[LAT];
    assign ks_data  = c_in;
    assign busy     = (state != IDLE);

endmodule
